sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
Parameterised successive-approximation ADC controller; next generation of the fixed 12-bit SAR logic in the Tiny Tapeout top.
- Adds: configurable resolution, sample/settle timing, multi-channel input mux select, start/abort handshake, channel-tagged result.
- Sits between the top-level pin wrapper and the analog comparator / capacitive DAC.

Parameters:
WIDTH, 12, conversion resolution in bits (>=4)
NCH, 4, number of analog input channels (>=1)
SAMPLE_CYC, 2, cycles the track/sample switch is closed per conversion (>=1)
SETTLE_CYC, 1, cycles per bit trial before the comparator is latched (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  request a conversion; accepted only in IDLE or DONE
ch_sel  in  max(1,$clog2(NCH))  channel to convert; latched at acceptance
abort  in  1  cancel an in-progress conversion
cmp_in  in  1  comparator output: 1 = input >= DAC code, so keep the trial bit
dac_code  out  WIDTH  DAC drive code
mux_sel  out  max(1,$clog2(NCH))  analog mux select (latched channel)
sample  out  1  track switch enable
busy  out  1  high in SAMPLE and CONV
result  out  WIDTH  last completed conversion; held until the next completion
result_ch  out  max(1,$clog2(NCH))  channel of result
valid  out  1  one-cycle pulse when result/result_ch update

Behaviour:
- Reset (async assert, sync release): state=IDLE; dac_code, mux_sel, result, result_ch = 0; sample, busy, valid = 0.
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE:
  - start=1 at edge k latches ch_sel into mux_sel and goes to SAMPLE.
  - A ch_sel value >= NCH is latched as NCH-1.
- SAMPLE:
  - sample=1 for exactly SAMPLE_CYC cycles; dac_code=0.
  - Then CONV with bit index = WIDTH-1 and the code register cleared.
- CONV:
  - Each bit i occupies SETTLE_CYC cycles.
  - dac_code = accumulated upper bits | (1<<i), lower bits 0.
  - On the last settle cycle's edge, cmp_in is sampled: 1 keeps bit i, 0 clears it.
  - i then decrements. After bit 0, result <= final code, result_ch <= mux_sel, and the state goes to DONE.
- DONE:
  - valid=1 for this one cycle; dac_code=0.
  - start=1 here goes directly to SAMPLE (back-to-back), latching the new ch_sel. Otherwise IDLE.
- Latency: acceptance edge k → valid high in cycle k + SAMPLE_CYC + WIDTH*SETTLE_CYC + 1. Defaults: cycle k+15.
- busy=1 exactly in SAMPLE and CONV. start is ignored while busy; it is not queued.
- abort=1 in SAMPLE or CONV:
  - Next state is IDLE; no valid; result and result_ch unchanged; dac_code=0, sample=0.
  - abort has priority over bit completion in the same cycle.
  - abort in IDLE/DONE has no effect; start and abort together in IDLE: start wins.
- Reset mid-conversion: immediate return to reset values; no valid.
- dac_code is 0 outside CONV.

Optional Feature:
Macro SAR_AVG4_EN.
- Defined:
  - Each accepted start runs 4 consecutive SAMPLE+CONV passes on the latched channel, with no DONE between passes.
  - Codes accumulate in a WIDTH+2-bit sum; result = (sum+2)>>2, round-half-up, never overflows.
  - valid pulses once, after the 4th pass. Latency = 4*(SAMPLE_CYC+WIDTH*SETTLE_CYC)+1.
  - abort discards the partial sum; busy stays high across all passes.
- Undefined: single conversion as above; no accumulator logic synthesised.

Test Plan:
- Defaults; comparator model vin=0xA5C (cmp_in = vin >= dac_code); start on ch_sel=2 at edge k → sample high k+1..k+2; dac_code=0x800 at k+3; valid only at k+15; result=0xA5C, result_ch=2.
- vin=0xFFF then vin=0x000 → result 0xFFF then 0x000; dac_code trial sequence in the zero case is 0x800, 0x400, …, 0x001.
- start held high continuously, ch_sel 1 then 3 → back-to-back conversions, valid every 15 cycles, result_ch alternates per latched channel; start pulses during busy produce no extra valid.
- abort asserted at the 5th CONV cycle → IDLE next cycle, no valid, result retains the previous 0xA5C; rst_n low mid-CONV → all outputs 0 asynchronously.
- WIDTH=8, SETTLE_CYC=3, NCH=3, ch_sel=3 → mux_sel=2; vin=0x5A → result 0x5A, valid at k+2+24+1=k+27.
- SAR_AVG4_EN, vin sequence 100, 101, 101, 102 → single valid at k+4*14+1=k+57 (defaults); result=101 ((404+2)>>2).

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller.
//
// Drives the analog mux select, the track/sample switch and the capacitive DAC
// code. It reads the comparator back one bit at a time, MSB first, and returns a
// channel-tagged result together with a one-cycle valid pulse.
//
// Parameters:
//   WIDTH       conversion resolution in bits (>=4)
//   NCH         number of analog input channels (>=1)
//   SAMPLE_CYC  cycles the track switch stays closed per conversion (>=1)
//   SETTLE_CYC  cycles per bit trial before the comparator is latched (>=1)
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       conversion request, accepted in IDLE or DONE
//   ch_sel      channel to convert; out-of-range values clamp to NCH-1
//   abort       cancels a conversion that is in SAMPLE or CONV
//   cmp_in      comparator output (1 = input >= dac_code, so the trial bit stays)
//   dac_code    DAC drive code; zero outside CONV
//   mux_sel     latched channel
//   sample      track switch enable
//   busy        high in SAMPLE and CONV
//   result      last completed code; held until the next completion
//   result_ch   channel of result
//   valid       one-cycle pulse when result/result_ch update
//
// Optional feature macro: SAR_AVG4_EN. When it is defined, every accepted start
// runs four SAMPLE+CONV passes. The result is then the rounded average
// ((sum+2)>>2) of the four codes.

module sar_adc_ctrl #(
  parameter int WIDTH      = 12,
  parameter int NCH        = 4,
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE_CYC = 1,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    ch_sel,
  input  logic             abort,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic [CW-1:0]    mux_sel,
  output logic             sample,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    result_ch,
  output logic             valid
);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

  localparam int CMAX  = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] SETL_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [WIDTH-1:0] MSB       = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;    // sample / settle cycle counter
  logic [WIDTH-1:0] mask;   // one-hot marker of the bit currently on trial
  logic [WIDTH-1:0] kept;   // dac_code with the trial bit resolved by cmp_in

  // dac_code already holds the resolved upper bits plus the trial bit.
  assign kept = cmp_in ? dac_code : (dac_code & ~mask);

  function automatic logic [CW-1:0] clamp_ch(input logic [CW-1:0] c);
    if (int'(c) >= NCH) return CW'(NCH - 1);
    return c;
  endfunction

`ifdef SAR_AVG4_EN
  logic [1:0]       pass;
  logic [WIDTH+1:0] sum;

  // Round half up. A sum of at most 4*(2^WIDTH-1) plus 2 still fits in
  // WIDTH+2 bits, so the extra bit is only headroom.
  function automatic logic [WIDTH-1:0] round_avg4(input logic [WIDTH+1:0] s);
    logic [WIDTH+2:0] t;
    t = {1'b0, s} + (WIDTH+3)'(2);
    return t[WIDTH+1:2];
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mask      <= '0;
      dac_code  <= '0;
      mux_sel   <= '0;
      sample    <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      result_ch <= '0;
      valid     <= 1'b0;
`ifdef SAR_AVG4_EN
      pass      <= '0;
      sum       <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= SAMPLE;
            mux_sel  <= clamp_ch(ch_sel);
            sample   <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            dac_code <= '0;
`ifdef SAR_AVG4_EN
            pass     <= '0;
            sum      <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end

        SAMPLE: begin
          if (abort) begin
            state    <= IDLE;
            sample   <= 1'b0;
            busy     <= 1'b0;
            cnt      <= '0;
            dac_code <= '0;
          end else if (cnt == SAMP_LAST) begin
            state    <= CONV;
            sample   <= 1'b0;
            cnt      <= '0;
            mask     <= MSB;
            dac_code <= MSB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CONV: begin
          // abort wins over a bit decision in the same cycle
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            mask     <= '0;
            dac_code <= '0;
          end else if (cnt == SETL_LAST) begin
            cnt <= '0;
            if (mask[0]) begin
              mask     <= '0;
              dac_code <= '0;
`ifdef SAR_AVG4_EN
              sum <= sum + {2'b00, kept};
              if (pass == 2'd3) begin
                result    <= round_avg4(sum + {2'b00, kept});
                result_ch <= mux_sel;
                valid     <= 1'b1;
                busy      <= 1'b0;
                state     <= DONE;
              end else begin
                pass   <= pass + 1'b1;
                sample <= 1'b1;
                state  <= SAMPLE;
              end
`else
              result    <= kept;
              result_ch <= mux_sel;
              valid     <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
`endif
            end else begin
              mask     <= mask >> 1;
              dac_code <= kept | (mask >> 1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Testbench for sar_adc_ctrl: a default 12-bit instance and an 8-bit,
// 3-channel, 3-cycle-settle instance. A behavioural comparator drives each
// instance. Expected results go into per-instance queues when a conversion
// starts. Monitors pop those queues and compare on every valid pulse.

module tb_sar_adc_ctrl;

`ifdef SAR_AVG4_EN
  localparam int LAT  = 4 * (2 + 12) + 1;
  localparam int LAT8 = 4 * (2 + 8 * 3) + 1;
`else
  localparam int LAT  = 2 + 12 + 1;
  localparam int LAT8 = 2 + 8 * 3 + 1;
`endif

  typedef struct {
    int res;
    int ch;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, cmp_in;
  logic [1:0]  ch_sel, mux_sel, result_ch;
  logic [11:0] dac_code, result, vin;
  logic        sample, busy, valid;

  logic        start8, abort8, cmp8;
  logic [1:0]  ch_sel8, mux_sel8, result_ch8;
  logic [7:0]  dac8, result8, vin8;
  logic        sample8, busy8, valid8;

  exp_t q[$];
  exp_t q8[$];
  int   errors = 0;
  int   checks = 0;
  int   valid_cnt = 0;
  int   valid_cnt8 = 0;
  logic [11:0] dac_tr [0:127];
  logic        smp_tr [0:127];
  int   bvin[4] = '{12'h3C7, 12'h0F1, 12'h7E2, 12'h01B};
  int   bch[4]  = '{1, 3, 1, 3};

  assign cmp_in = (vin >= dac_code);
  assign cmp8   = (vin8 >= dac8);

  always #5 clk = ~clk;

  sar_adc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_sel(ch_sel), .abort(abort),
    .cmp_in(cmp_in), .dac_code(dac_code), .mux_sel(mux_sel), .sample(sample),
    .busy(busy), .result(result), .result_ch(result_ch), .valid(valid)
  );

  sar_adc_ctrl #(.WIDTH(8), .NCH(3), .SAMPLE_CYC(2), .SETTLE_CYC(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .ch_sel(ch_sel8), .abort(abort8),
    .cmp_in(cmp8), .dac_code(dac8), .mux_sel(mux_sel8), .sample(sample8),
    .busy(busy8), .result(result8), .result_ch(result_ch8), .valid(valid8)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", int'(result), e.res);
        chk("result_ch", int'(result_ch), e.ch);
      end
    end
  end

  always @(negedge clk) begin
    if (valid8) begin
      valid_cnt8++;
      if (q8.size() == 0) begin
        chk("unexpected_valid8", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("result8", int'(result8), e.res);
        chk("result_ch8", int'(result_ch8), e.ch);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // One conversion on the 12-bit instance, started at the current negedge.
  // n counts negedges after the acceptance edge, so n matches "cycle k+n".
  task automatic run_conv(input logic [11:0] v, input logic [1:0] ch,
                          input int exp_ch, output int lat);
    vin = v; ch_sel = ch; start = 1'b1;
    q.push_back('{int'(v), exp_ch});
    lat = -1;
    for (int n = 1; n <= LAT + 5; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      dac_tr[n] = dac_code;
      smp_tr[n] = sample;
      if (valid) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int vc;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ch_sel = '0; vin = '0;
    start8 = 1'b0; abort8 = 1'b0; ch_sel8 = '0; vin8 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dac", int'(dac_code), 0);
    chk("rst_mux", int'(mux_sel), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_result_ch", int'(result_ch), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // vin=0xA5C on channel 2: timing of sample, first trial and valid
    run_conv(12'hA5C, 2'd2, 2, lat);
    chk("a5c_latency", lat, LAT);
    chk("a5c_sample_k1", int'(smp_tr[1]), 1);
    chk("a5c_sample_k2", int'(smp_tr[2]), 1);
    chk("a5c_sample_k3", int'(smp_tr[3]), 0);
    chk("a5c_dac_k1", int'(dac_tr[1]), 0);
    chk("a5c_dac_k3", int'(dac_tr[3]), 12'h800);
    @(negedge clk);
    chk("done_dac_zero", int'(dac_code), 0);

    // abort in the 5th CONV cycle (k+7): nothing completes, result held
    vc = valid_cnt;
    vin = 12'h123; ch_sel = 2'd1; start = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sample", int'(sample), 0);
    chk("abort_dac", int'(dac_code), 0);
    repeat (LAT + 5) @(negedge clk);
    chk("abort_no_valid", valid_cnt - vc, 0);
    chk("abort_result_held", int'(result), 12'hA5C);
    chk("abort_result_ch_held", int'(result_ch), 2);

    // Full-scale and zero inputs; zero case walks the trial bit down
    run_conv(12'hFFF, 2'd0, 0, lat);
    chk("fff_latency", lat, LAT);
    @(negedge clk);
    run_conv(12'h000, 2'd3, 3, lat);
    chk("zero_latency", lat, LAT);
    for (int i = 0; i < 12; i++)
      chk($sformatf("zero_trial_%0d", i), int'(dac_tr[3 + i]), 12'h800 >> i);
    @(negedge clk);

    // start held high: back-to-back conversions, channel alternates 1/3
    vc = valid_cnt;
    vin = bvin[0][11:0]; ch_sel = 2'd1; start = 1'b1;
    q.push_back('{bvin[0], bch[0]});
    for (int c = 0; c < 4; c++) begin
      lat = -1;
      for (int n = 1; n <= LAT + 5; n++) begin
        @(negedge clk);
        if (n == 1) ch_sel = 2'(bch[(c + 1) % 4]);
        if (valid) begin
          lat = n;
          if (c < 3) begin
            vin = bvin[c + 1][11:0];
            q.push_back('{bvin[c + 1], bch[c + 1]});
          end else begin
            start = 1'b0;
          end
          break;
        end
      end
      chk($sformatf("b2b_interval_%0d", c), lat, LAT);
    end
    repeat (LAT + 5) @(negedge clk);
    chk("b2b_valid_count", valid_cnt - vc, 4);

    // start pulses while busy are neither accepted nor queued
    vc = valid_cnt;
    vin = 12'h5A5; ch_sel = 2'd2; start = 1'b1;
    q.push_back('{32'h5A5, 2});
    lat = -1;
    for (int n = 1; n <= LAT + 5; n++) begin
      @(negedge clk);
      start = (n == 4 || n == 9);
      if (valid) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    chk("busy_start_latency", lat, LAT);
    repeat (2 * LAT) @(negedge clk);
    chk("busy_start_valids", valid_cnt - vc, 1);

    // 8-bit instance: out-of-range ch_sel clamps to 2, settle of 3 cycles
    vin8 = 8'h5A; ch_sel8 = 2'd3; start8 = 1'b1;
    q8.push_back('{32'h5A, 2});
    lat = -1;
    for (int n = 1; n <= LAT8 + 5; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start8 = 1'b0;
        chk("w8_mux_clamp", int'(mux_sel8), 2);
      end
      if (n == 3) chk("w8_first_trial", int'(dac8), 8'h80);
      if (valid8) begin
        lat = n;
        break;
      end
    end
    chk("w8_latency", lat, LAT8);
    @(negedge clk);

`ifdef SAR_AVG4_EN
    // Four passes with vin 100,101,101,102: (404+2)>>2 = 101
    vin = 12'd100; ch_sel = 2'd0; start = 1'b1;
    q.push_back('{101, 0});
    lat = -1;
    for (int n = 1; n <= LAT + 5; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 1 + 14) vin = 12'd101;
      if (n == 1 + 28) vin = 12'd101;
      if (n == 1 + 42) vin = 12'd102;
      if (n < LAT) chk($sformatf("avg_busy_%0d", n), int'(busy), 1);
      if (valid) begin
        lat = n;
        break;
      end
    end
    chk("avg_latency", lat, LAT);
    @(negedge clk);
`endif

    // Reset in mid-CONV clears everything at once
    vc = valid_cnt;
    vin = 12'h777; ch_sel = 2'd3; start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dac", int'(dac_code), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_sample", int'(sample), 0);
    chk("arst_mux", int'(mux_sel), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_result_ch", int'(result_ch), 0);
    chk("arst_valid", int'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    chk("arst_no_valid", valid_cnt - vc, 0);

    chk("queue_empty", q.size(), 0);
    chk("queue8_empty", q8.size(), 0);
    chk("valid8_count", valid_cnt8, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
